// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - Mode encodings, strobe-rate constants and helpers shared by the LED hold bank
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'b00,
        LED_HOLD  = 2'b01,
        LED_BLINK = 2'b10,
        LED_LATCH = 2'b11
    } led_mode_t;

    // Divider targets for the board tick generator that feeds tick_1s / tick_blink
    localparam int unsigned LED_CLK_HZ          = 50_000_000;
    localparam int unsigned LED_SEC_STROBE_HZ   = 1;
    localparam int unsigned LED_BLINK_STROBE_HZ = 4;
    localparam int unsigned LED_SEC_DIV         = LED_CLK_HZ / LED_SEC_STROBE_HZ;
    localparam int unsigned LED_BLINK_DIV       = LED_CLK_HZ / LED_BLINK_STROBE_HZ;

    function automatic logic led_is_timed(input led_mode_t m);
        return (m == LED_HOLD) || (m == LED_BLINK);
    endfunction

endpackage

// File: rtl/led_hold_chan.sv
// rtl/led_hold_chan.sv - One LED channel: hold counter, latch, blink toggle and expiry pulse
module led_hold_chan
    import led_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int HOLD_TICKS = 3,
    parameter bit RETRIGGER  = 1'b1
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      tick_1s,
    input  logic      tick_blink,
    input  logic      event_pulse,
    input  logic      clear,
    input  led_mode_t mode,
    output logic      led,
    output logic      active,
    output logic      expire
);

    generate
        if (HOLD_TICKS < 1 || HOLD_TICKS > (2 ** CNT_W) - 1) begin : g_bad_hold
            $error("led_hold_chan: HOLD_TICKS out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             latch_q, latch_d;
    logic             led_q, led_d;
    logic             expire_q, expire_d;
    led_mode_t        mode_q;
    logic             idle;
    logic             accept;
    logic             mode_chg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            latch_q  <= 1'b0;
            led_q    <= 1'b0;
            expire_q <= 1'b0;
            mode_q   <= LED_OFF;
        end else begin
            count_q  <= count_d;
            latch_q  <= latch_d;
            led_q    <= led_d;
            expire_q <= expire_d;
            mode_q   <= mode;
        end
    end

    always_comb begin
        count_d  = count_q;
        latch_d  = latch_q;
        led_d    = led_q;
        expire_d = 1'b0;
        idle     = (count_q == '0) && !latch_q;
        accept   = event_pulse && (idle || RETRIGGER);
        mode_chg = (mode != mode_q);

        if (mode == LED_OFF || clear) begin
            count_d = '0;
            latch_d = 1'b0;
            led_d   = 1'b0;
        end else if (accept) begin
            // An accepted reload also swallows a coincident tick_1s
            led_d = 1'b1;
            if (mode == LED_LATCH) begin
                latch_d = 1'b1;
            end else begin
                count_d = HOLD_LOAD;
                latch_d = 1'b0;
            end
        end else if (!led_is_timed(mode)) begin
            // LATCH: counter frozen, led follows whatever keeps the channel active
            led_d = latch_q || (count_q != '0);
        end else begin
            latch_d = 1'b0;
            if (count_q == '0) begin
                led_d = 1'b0;
            end else if (tick_1s && count_q == CNT_ONE) begin
                count_d  = '0;
                led_d    = 1'b0;
                expire_d = 1'b1;
            end else begin
                if (tick_1s) begin
                    count_d = count_q - CNT_ONE;
                end
                if (mode == LED_HOLD || mode_chg) begin
                    led_d = 1'b1;
                end else if (tick_blink) begin
                    led_d = !led_q;
                end
            end
        end
    end

    assign led    = led_q;
    assign expire = expire_q;
    assign active = (count_q != '0) || latch_q;

endmodule

// File: rtl/led_hold_bank.sv
// rtl/led_hold_bank.sv - N independent LED hold/blink/latch channels driven by shared strobes
module led_hold_bank
    import led_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 8,
    parameter int HOLD_TICKS = 3,
    parameter bit RETRIGGER  = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick_1s,
    input  logic              tick_blink,
    input  logic [N_CH-1:0]   event_pulse,
    input  logic [N_CH-1:0]   clear,
    input  logic [2*N_CH-1:0] mode,
    output logic [N_CH-1:0]   led,
    output logic [N_CH-1:0]   active,
    output logic [N_CH-1:0]   expire
);

    generate
        if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
            $error("led_hold_bank: N_CH must be 1..16");
        end

        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            led_hold_chan #(
                .CNT_W      (CNT_W),
                .HOLD_TICKS (HOLD_TICKS),
                .RETRIGGER  (RETRIGGER)
            ) u_chan (
                .clk         (clk),
                .reset_n     (reset_n),
                .tick_1s     (tick_1s),
                .tick_blink  (tick_blink),
                .event_pulse (event_pulse[i]),
                .clear       (clear[i]),
                .mode        (led_mode_t'(mode[2*i +: 2])),
                .led         (led[i]),
                .active      (active[i]),
                .expire      (expire[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_led_hold_bank.sv
// tb/tb_led_hold_bank.sv - Directed and random checks of led_hold_bank against a behavioural model
module tb_led_hold_bank;

    localparam int N    = 4;
    localparam int HOLD = 3;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           tick_1s, tick_blink;
    logic [N-1:0]   event_pulse, clear;
    logic [2*N-1:0] mode;
    logic [N-1:0]   a_led, a_act, a_exp;
    logic [N-1:0]   b_led, b_act, b_exp;

    int errors = 0;
    int checks = 0;

    // Model: remaining seconds, latched flag, led, expire, last seen mode (index 0 retrigger, 1 not)
    int       rem [2][N];
    bit       lat [2][N];
    bit       ledm[2][N];
    bit       expm[2][N];
    int       pm  [2][N];

    led_hold_bank #(.N_CH(N), .CNT_W(8), .HOLD_TICKS(HOLD), .RETRIGGER(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .tick_1s(tick_1s), .tick_blink(tick_blink),
        .event_pulse(event_pulse), .clear(clear), .mode(mode),
        .led(a_led), .active(a_act), .expire(a_exp)
    );

    led_hold_bank #(.N_CH(N), .CNT_W(8), .HOLD_TICKS(HOLD), .RETRIGGER(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .tick_1s(tick_1s), .tick_blink(tick_blink),
        .event_pulse(event_pulse), .clear(clear), .mode(mode),
        .led(b_led), .active(b_act), .expire(b_exp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int r, input int i, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d ch%0d t=%0t got %b expected %b", tag, r, i, $time, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s t=%0t got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) begin
                rem[r][i] = 0; lat[r][i] = 0; ledm[r][i] = 0; expm[r][i] = 0; pm[r][i] = 0;
            end
    endfunction

    function automatic void model_ch(input int r, input int i);
        int m       = int'(mode[2*i +: 2]);
        bit busy    = (rem[r][i] > 0) || lat[r][i];
        bit changed = (m != pm[r][i]);
        bit may_re  = (r == 0);
        pm[r][i]   = m;
        expm[r][i] = 0;
        if (m == 0 || clear[i]) begin
            rem[r][i] = 0; lat[r][i] = 0; ledm[r][i] = 0;
            return;
        end
        if (event_pulse[i] && (!busy || may_re)) begin
            ledm[r][i] = 1;
            if (m == 3) lat[r][i] = 1;
            else begin rem[r][i] = HOLD; lat[r][i] = 0; end
            return;
        end
        if (m == 3) begin
            ledm[r][i] = busy;
            return;
        end
        lat[r][i] = 0;
        if (rem[r][i] == 0) begin
            ledm[r][i] = 0;
            return;
        end
        if (tick_1s) rem[r][i] = rem[r][i] - 1;
        if (rem[r][i] == 0) begin
            ledm[r][i] = 0; expm[r][i] = 1;
        end else if (m == 1 || changed) begin
            ledm[r][i] = 1;
        end else if (tick_blink) begin
            ledm[r][i] = !ledm[r][i];
        end
    endfunction

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk("led",    0, i, a_led[i], ledm[0][i]);
            chk("active", 0, i, a_act[i], (rem[0][i] > 0) || lat[0][i]);
            chk("expire", 0, i, a_exp[i], expm[0][i]);
            chk("led",    1, i, b_led[i], ledm[1][i]);
            chk("active", 1, i, b_act[i], (rem[1][i] > 0) || lat[1][i]);
            chk("expire", 1, i, b_exp[i], expm[1][i]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (!reset_n) model_reset();
        else for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) model_ch(r, i);
        check_all();
    endtask

    task automatic quiet();
        event_pulse = '0; clear = '0; tick_1s = 1'b0; tick_blink = 1'b0;
    endtask

    initial begin
        int led_hi, led_lo, exp_n, b_hi, exp2, exp0;
        reset_n = 1'b0; mode = 8'h55; quiet();
        model_reset();
        cycle(); cycle();
        reset_n = 1'b1;
        cycle();

        // reset in the middle of a hold, then a tick after release must not expire
        event_pulse = 4'b0001; cycle(); quiet();
        tick_1s = 1'b1; cycle(); quiet();
        reset_n = 1'b0; #1; model_reset(); check_all();
        cycle(); reset_n = 1'b1; cycle();
        tick_1s = 1'b1; cycle(); quiet(); cycle();

        // HOLD: event then ticks at k=10,20,30
        led_hi = 0; exp_n = 0;
        for (int k = 0; k < 36; k++) begin
            event_pulse = (k == 0) ? 4'b0001 : 4'b0000;
            tick_1s = (k % 10 == 0) && (k > 0);
            cycle(); quiet();
            led_hi += int'(a_led[0]); exp_n += int'(a_exp[0]);
        end
        chk_int("hold_led_cycles", led_hi, 30);
        chk_int("hold_expires", exp_n, 1);

        // Retrigger: second event coincident with the third tick
        led_hi = 0; b_hi = 0;
        for (int k = 0; k < 70; k++) begin
            event_pulse = (k == 0 || k == 30) ? 4'b0001 : 4'b0000;
            tick_1s = (k % 10 == 0) && (k > 0);
            cycle(); quiet();
            led_hi += int'(a_led[0]); b_hi += int'(b_led[0]);
        end
        chk_int("retrig_led_cycles", led_hi, 60);
        chk_int("noretrig_led_cycles", b_hi, 30);

        // BLINK: blink strobe every 5, tick every 10, last blink coincides with expiry
        mode = 8'h56; cycle();
        exp_n = 0;
        for (int k = 0; k < 36; k++) begin
            event_pulse = (k == 0) ? 4'b0001 : 4'b0000;
            tick_1s = (k % 10 == 9);
            tick_blink = (k % 5 == 4);
            cycle(); quiet();
            exp_n += int'(a_exp[0]);
        end
        chk_int("blink_expires", exp_n, 1);
        chk("blink_led_end", 0, 0, a_led[0], 1'b0);

        // LATCH: ten ticks change nothing, clear wins over a same-cycle event
        mode = 8'h57; cycle();
        led_lo = 0; exp_n = 0;
        for (int k = 0; k < 31; k++) begin
            event_pulse = (k == 0) ? 4'b0001 : 4'b0000;
            tick_1s = (k % 3 == 2);
            cycle(); quiet();
            if (k > 0) led_lo += int'(!a_led[0]);
            exp_n += int'(a_exp[0]);
        end
        chk_int("latch_led_low", led_lo, 0);
        chk_int("latch_expires", exp_n, 0);
        clear = 4'b0001; event_pulse = 4'b0001; cycle(); quiet();
        chk("latch_clear_led", 0, 0, a_led[0], 1'b0);
        chk("latch_clear_act", 0, 0, a_act[0], 1'b0);

        // Independence: all channels fire, ch2 switched OFF mid-hold
        mode = 8'hD9; cycle();
        exp2 = 0; exp0 = 0;
        for (int k = 0; k < 40; k++) begin
            event_pulse = (k == 0) ? 4'b1111 : 4'b0000;
            if (k == 12) mode = 8'hC9;
            tick_1s = (k % 10 == 9);
            tick_blink = (k % 4 == 3);
            cycle(); quiet();
            if (k == 12) chk("off_led_next", 0, 2, a_led[2], 1'b0);
            exp2 += int'(a_exp[2]); exp0 += int'(a_exp[0]);
        end
        chk_int("off_no_expire", exp2, 0);
        chk_int("indep_ch0_expire", exp0, 1);
        chk("indep_ch3_latched", 0, 3, a_led[3], 1'b1);

        // Random traffic
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < N; i++) begin
                event_pulse[i] = ($urandom_range(0, 11) == 0);
                clear[i]       = ($urandom_range(0, 79) == 0);
                if ($urandom_range(0, 59) == 0) mode[2*i +: 2] = 2'($urandom_range(0, 3));
            end
            tick_1s    = ($urandom_range(0, 7) == 0);
            tick_blink = ($urandom_range(0, 2) == 0);
            reset_n    = ($urandom_range(0, 499) != 0);
            cycle();
        end
        quiet(); reset_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
